// File: rtl/rca_pipe_if.sv
// Handshake bundle for rca_pipe: operands and result with valid/ready on each side.
// The sub_i member exists only when RCA_PIPE_SUB_EN is defined.
interface rca_pipe_if #(
    parameter int WIDTH = 9
) ();
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic             cin_i;
`ifdef RCA_PIPE_SUB_EN
    logic             sub_i;
`endif
    logic             in_valid_i;
    logic             in_ready_o;
    logic [WIDTH:0]   sum_o;
    logic             out_valid_o;
    logic             out_ready_i;

    // Directions are named from the adder's point of view.
    modport slave (
`ifdef RCA_PIPE_SUB_EN
        input  sub_i,
`endif
        input  a_i, b_i, cin_i, in_valid_i, out_ready_i,
        output in_ready_o, sum_o, out_valid_o
    );

    modport master (
`ifdef RCA_PIPE_SUB_EN
        output sub_i,
`endif
        output a_i, b_i, cin_i, in_valid_i, out_ready_i,
        input  in_ready_o, sum_o, out_valid_o
    );
endinterface

// File: rtl/rca_pipe.sv
// Pipelined ripple-carry adder: one CHUNK-bit slice added per stage, global stall.
// Optional subtract mode enabled by defining RCA_PIPE_SUB_EN.
module rca_pipe #(
    parameter int WIDTH  = 9,
    parameter int STAGES = 3
) (
    input logic      clk_i,
    input logic      rst_ni,
    rca_pipe_if.slave bus
);
    localparam int CHUNK = (STAGES > 0) ? WIDTH / STAGES : WIDTH;

    if (STAGES < 1 || (WIDTH % STAGES) != 0) begin : gBadCfg
        $error("rca_pipe: WIDTH must be a multiple of STAGES and STAGES >= 1");
    end
    if ($bits(bus.a_i) != WIDTH) begin : gBadIf
        $error("rca_pipe: interface WIDTH does not match module WIDTH");
    end

    logic adv;
    assign adv            = !bus.out_valid_o || bus.out_ready_i;
    assign bus.in_ready_o = adv;

    // Subtraction is folded in at the entry: invert B and force the carry-in.
    logic [WIDTH-1:0] bEff;
    logic             cinEff;
`ifdef RCA_PIPE_SUB_EN
    assign bEff   = bus.sub_i ? ~bus.b_i : bus.b_i;
    assign cinEff = bus.sub_i ? 1'b1 : bus.cin_i;
`else
    assign bEff   = bus.b_i;
    assign cinEff = bus.cin_i;
`endif

    for (genvar k = 0; k < STAGES; k++) begin : gStage
        localparam int PW = CHUNK * (k + 1);
        localparam int RW = WIDTH - PW;

        logic [CHUNK-1:0] aChunk;
        logic [CHUNK-1:0] bChunk;
        logic             carryIn;
        logic [CHUNK:0]   chunkSum;
        logic             valid_d;
        logic             valid_q;
        logic             carry_q;
        logic [PW-1:0]    psum_d;
        logic [PW-1:0]    psum_q;

        if (k == 0) begin : gHead
            assign aChunk  = bus.a_i[CHUNK-1:0];
            assign bChunk  = bEff[CHUNK-1:0];
            assign carryIn = cinEff;
            assign valid_d = bus.in_valid_i;
            assign psum_d  = chunkSum[CHUNK-1:0];
        end else begin : gBody
            assign aChunk  = gStage[k-1].gOps.opA_q[CHUNK-1:0];
            assign bChunk  = gStage[k-1].gOps.opB_q[CHUNK-1:0];
            assign carryIn = gStage[k-1].carry_q;
            assign valid_d = gStage[k-1].valid_q;
            assign psum_d  = {chunkSum[CHUNK-1:0], gStage[k-1].psum_q};
        end

        assign chunkSum = {1'b0, aChunk} + {1'b0, bChunk} + {{CHUNK{1'b0}}, carryIn};

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                valid_q <= 1'b0;
                carry_q <= 1'b0;
                psum_q  <= '0;
            end else if (adv) begin
                valid_q <= valid_d;
                carry_q <= chunkSum[CHUNK];
                psum_q  <= psum_d;
            end
        end

        // Unconsumed operand slices travel alongside, lowest pending slice at bit 0.
        if (k < STAGES - 1) begin : gOps
            logic [RW-1:0] opA_d;
            logic [RW-1:0] opB_d;
            logic [RW-1:0] opA_q;
            logic [RW-1:0] opB_q;

            if (k == 0) begin : gOpsHead
                assign opA_d = bus.a_i[WIDTH-1:CHUNK];
                assign opB_d = bEff[WIDTH-1:CHUNK];
            end else begin : gOpsBody
                assign opA_d = gStage[k-1].gOps.opA_q[RW+CHUNK-1:CHUNK];
                assign opB_d = gStage[k-1].gOps.opB_q[RW+CHUNK-1:CHUNK];
            end

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    opA_q <= '0;
                    opB_q <= '0;
                end else if (adv) begin
                    opA_q <= opA_d;
                    opB_q <= opB_d;
                end
            end
        end
    end

    assign bus.out_valid_o = gStage[STAGES-1].valid_q;
    assign bus.sum_o       = {gStage[STAGES-1].carry_q, gStage[STAGES-1].psum_q};
endmodule

// File: tb/tb_rca_pipe.sv
// Directed + randomized bench for rca_pipe (WIDTH=9, STAGES=3) with a queue scoreboard.
// Define RCA_PIPE_SUB_EN on both bench and RTL to exercise subtract mode.
module tb_rca_pipe;
    localparam int WIDTH  = 9;
    localparam int STAGES = 3;
    localparam int MASK   = (1 << WIDTH) - 1;

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b1;

    rca_pipe_if #(.WIDTH(WIDTH)) bus ();

    rca_pipe #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    int          vectors     = 0;
    int          miscompares = 0;
    int          popCount    = 0;
    int unsigned expQ[$];
    int unsigned pendingExp;
    bit          lastInXfer;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input int unsigned obs, input int unsigned exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $display("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
            $error("[TB] check %s", tag);
        end
    endtask

    function automatic int unsigned model(input int unsigned a, input int unsigned b,
                                          input int unsigned cin, input bit sub);
        if (sub) return a + ((~b) & MASK) + 1;
        return a + b + cin;
    endfunction

    task automatic applyStimulus(input int unsigned a, input int unsigned b,
                                 input int unsigned cin, input bit sub, input bit valid);
        bus.a_i        = WIDTH'(a);
        bus.b_i        = WIDTH'(b);
        bus.cin_i      = cin[0];
`ifdef RCA_PIPE_SUB_EN
        bus.sub_i      = sub;
`endif
        bus.in_valid_i = valid;
        pendingExp     = model(a, b, cin, sub);
    endtask

    // Scoreboard work happens on the falling edge, where inputs and outputs are settled.
    task automatic tick();
        @(negedge clk_i);
        lastInXfer = bus.in_valid_i && bus.in_ready_o && rst_ni;
        checkOutput("in_ready_rule", bus.in_ready_o, !bus.out_valid_o || bus.out_ready_i);
        if (bus.out_valid_o && bus.out_ready_i) begin
            if (expQ.size() == 0) begin
                checkOutput("spurious_out", bus.out_valid_o, 0);
            end else begin
                checkOutput("sum_sb", bus.sum_o, expQ.pop_front());
                popCount++;
            end
        end
        if (lastInXfer) expQ.push_back(pendingExp);
        @(posedge clk_i);
        #1;
    endtask

    task automatic sendOp(input int unsigned a, input int unsigned b, input int unsigned cin,
                          input bit sub, input bit randReady);
        bit accepted = 1'b0;
        applyStimulus(a, b, cin, sub, 1'b1);
        for (int w = 0; w < 50; w++) begin
            if (randReady) bus.out_ready_i = ($urandom_range(0, 3) != 0);
            tick();
            if (lastInXfer) begin
                accepted = 1'b1;
                break;
            end
        end
        if (!accepted) checkOutput("op_accept", 0, 1);
    endtask

    task automatic drain();
        applyStimulus(0, 0, 0, 1'b0, 1'b0);
        bus.out_ready_i = 1'b1;
        for (int w = 0; w < 40 && expQ.size() != 0; w++) tick();
        checkOutput("drain_empty", expQ.size(), 0);
        tick();
    endtask

    initial begin
        int unsigned streamExp[4] = '{7, 301, 1023, 0};
        int unsigned streamOps[4][3] = '{'{3, 4, 0}, '{100, 200, 1}, '{511, 511, 1}, '{0, 0, 0}};
        int unsigned corners[5] = '{0, 1, 255, 256, 511};
        int          popStart;

        applyStimulus(0, 0, 0, 1'b0, 1'b0);
        bus.out_ready_i = 1'b1;

        // Asynchronous reset with no clock edge in between.
        #2 rst_ni = 1'b0;
        #1;
        checkOutput("rst_out_valid", bus.out_valid_o, 0);
        checkOutput("rst_sum", bus.sum_o, 0);
        checkOutput("rst_in_ready", bus.in_ready_o, 1);
        @(posedge clk_i);
        #1;
        tick();
        rst_ni = 1'b1;
        tick();

        // Full carry ripple through every stage boundary.
        sendOp(511, 1, 0, 1'b0, 1'b0);
        applyStimulus(0, 0, 0, 1'b0, 1'b0);
        checkOutput("ripple_t1_valid", bus.out_valid_o, 0);
        tick();
        checkOutput("ripple_t2_valid", bus.out_valid_o, 0);
        tick();
        checkOutput("ripple_t3_valid", bus.out_valid_o, 1);
        checkOutput("ripple_t3_sum", bus.sum_o, 512);
        tick();
        checkOutput("ripple_t4_valid", bus.out_valid_o, 0);

        // Back-to-back stream, results on consecutive cycles 3..6.
        popStart = popCount;
        for (int c = 0; c < 8; c++) begin
            checkOutput("stream_valid", bus.out_valid_o, (c >= 3 && c <= 6) ? 1 : 0);
            if (c >= 3 && c <= 6) checkOutput("stream_sum", bus.sum_o, streamExp[c-3]);
            if (c < 4) applyStimulus(streamOps[c][0], streamOps[c][1], streamOps[c][2], 1'b0, 1'b1);
            else applyStimulus(0, 0, 0, 1'b0, 1'b0);
            tick();
        end
        checkOutput("stream_count", popCount - popStart, 4);

        // Backpressure: fill, stall two cycles, release.
        popStart = popCount;
        sendOp(10, 20, 0, 1'b0, 1'b0);
        sendOp(300, 300, 1, 1'b0, 1'b0);
        sendOp(511, 0, 1, 1'b0, 1'b0);
        applyStimulus(128, 127, 1, 1'b0, 1'b1);
        bus.out_ready_i = 1'b0;
        #1;
        for (int c = 0; c < 2; c++) begin
            checkOutput("bp_in_ready", bus.in_ready_o, 0);
            checkOutput("bp_valid", bus.out_valid_o, 1);
            checkOutput("bp_sum_hold", bus.sum_o, 30);
            tick();
        end
        checkOutput("bp_sum_after", bus.sum_o, 30);
        bus.out_ready_i = 1'b1;
        sendOp(128, 127, 1, 1'b0, 1'b0);
        drain();
        checkOutput("bp_count", popCount - popStart, 4);

        // Reset in the middle of three in-flight operations.
        sendOp(5, 6, 0, 1'b0, 1'b0);
        sendOp(100, 1, 1, 1'b0, 1'b0);
        sendOp(256, 256, 0, 1'b0, 1'b0);
        applyStimulus(0, 0, 0, 1'b0, 1'b0);
        #1 rst_ni = 1'b0;
        #1;
        checkOutput("midrst_valid", bus.out_valid_o, 0);
        checkOutput("midrst_sum", bus.sum_o, 0);
        checkOutput("midrst_in_ready", bus.in_ready_o, 1);
        expQ.delete();
        tick();
        tick();
        #2 rst_ni = 1'b1;
        for (int c = 0; c < 5; c++) begin
            checkOutput("midrst_no_stale", bus.out_valid_o, 0);
            tick();
        end
        sendOp(200, 55, 1, 1'b0, 1'b0);
        applyStimulus(0, 0, 0, 1'b0, 1'b0);
        checkOutput("midrst_t1_valid", bus.out_valid_o, 0);
        tick();
        checkOutput("midrst_t2_valid", bus.out_valid_o, 0);
        tick();
        checkOutput("midrst_t3_valid", bus.out_valid_o, 1);
        checkOutput("midrst_t3_sum", bus.sum_o, 256);
        drain();

        // Corner pairs then random operands, with random downstream readiness.
        for (int i = 0; i < 2000; i++) begin
            int unsigned a, b, cin;
            if (i < 50) begin
                a   = corners[(i / 5) % 5];
                b   = corners[i % 5];
                cin = (i / 25) % 2;
            end else begin
                a   = $urandom_range(0, MASK);
                b   = $urandom_range(0, MASK);
                cin = $urandom_range(0, 1);
            end
            sendOp(a, b, cin, 1'b0, 1'b1);
        end
        drain();

`ifdef RCA_PIPE_SUB_EN
        sendOp(5, 7, 0, 1'b1, 1'b0);
        sendOp(7, 5, 1, 1'b1, 1'b0);
        sendOp(300, 300, 0, 1'b1, 1'b0);
        sendOp(7, 5, 1, 1'b0, 1'b0);
        drain();
`endif

        checkOutput("final_queue_empty", expQ.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
